apb_fabric: RTL and testbench
=============================

# apb_fabric

Parametrised APB3 decoder/interconnect between the core's single APB master port and `NUM_SLAVES` peripheral ports. It decodes each transfer against per-slave base/mask windows and locks the decoded slave for the whole transfer. Unmapped accesses, stalled slaves (timeout watchdog) and slave errors complete with `pslverr`. The first error is captured in a sticky fault record. Address, write data, `pwrite` and `pstrb` are wired from master to all slaves at the top level; this block routes only select, enable, read data, ready and error.

## Interface
- `ADDR_WIDTH`, 32, address width.
- `DATA_WIDTH`, 32, data width.
- `NUM_SLAVES`, 3, number of slave ports (1..16).
- `SLAVE_BASE`, {'h80000000,'h10000000,'h00000000}, `NUM_SLAVES*ADDR_WIDTH` flattened bases; slave i at bits [i*ADDR_WIDTH +: ADDR_WIDTH].
- `SLAVE_MASK`, {'h80000000,'hFFFFFFF8,'hFFFF0000}, same layout. Slave i hits when `(paddr & MASK_i) == BASE_i`.
- `TIMEOUT_CYCLES`, 16, access cycles allowed before timeout; 0 disables the watchdog.
- `pclk` in 1: clock, all logic on the rising edge.
- `presetn` in 1: reset, asynchronous, active-low.
- `paddr` in `ADDR_WIDTH`: master address.
- `psel` in 1: master select.
- `penable` in 1: master enable.
- `prdata` out `DATA_WIDTH`: read data to master.
- `pready` out 1: transfer complete.
- `pslverr` out 1: transfer error, valid only while `pready`=1.
- `s_psel` out `NUM_SLAVES`: per-slave select.
- `s_penable` out `NUM_SLAVES`: per-slave enable.
- `s_prdata` in `NUM_SLAVES*DATA_WIDTH`: flattened slave read data.
- `s_pready` in `NUM_SLAVES`: per-slave ready.
- `s_pslverr` in `NUM_SLAVES`: per-slave error.
- `fault_valid` out 1: sticky, an error has been captured.
- `fault_addr` out `ADDR_WIDTH`: address of the first captured error.
- `fault_code` out 2: cause; 01 = decode miss, 10 = timeout, 11 = slave error.
- `fault_clr` in 1: single-cycle clear of the fault record.

## Operation
- States: IDLE and ACCESS. Registers: state, `sel_idx` (slave index), `miss`, `lat_addr`, timeout counter `tcnt`, and the fault record.
- **Decode**
  - Combinational from `paddr`, priority decoding: the lowest hitting index wins.
  - No hit → miss.
- **IDLE, setup phase** (`psel`=1, `penable`=0):
  - `s_psel[hit]` = 1, driven combinationally from the decode.
  - On the clock edge: latch `sel_idx`, `miss` and `lat_addr`; set `tcnt`=0; go to ACCESS.
- **IDLE, enable without setup** (`psel`=1, `penable`=1):
  - Protocol violation.
  - Same cycle: `pready`=1, `pslverr`=1, `prdata`=0.
  - Fault captured with code 01 and the current `paddr`. Stay in IDLE.
- **ACCESS**
  - Routing uses the latched `sel_idx` only; `paddr` changes are ignored.
  - Outputs: `s_psel[sel_idx]`=`psel`, `s_penable[sel_idx]`=`penable`, `prdata`=`s_prdata[sel_idx]`, `pready`=`s_pready[sel_idx]`, `pslverr`=`s_pslverr[sel_idx]`. All other slave selects are 0.
  - Miss: `pready`=1, `pslverr`=1, `prdata`=0 in the first ACCESS cycle; no slave selected.
  - Timeout (when `TIMEOUT_CYCLES`≠0):
    - `tcnt` increments each ACCESS cycle with the selected `s_pready`=0.
    - If `tcnt` == `TIMEOUT_CYCLES`-1 and `s_pready`=0, the block forces `pready`=1, `pslverr`=1, `prdata`=0 and drops `s_psel`/`s_penable` to that slave.
    - A late slave ready is ignored.
  - Leaving ACCESS: on the completing cycle, go to IDLE. A new setup in the following cycle is a normal back-to-back transfer.
  - Master abort (`psel` falls in ACCESS): return to IDLE, no completion, no fault.
- **Fault record**
  - Any completion with `pslverr`=1: if `fault_valid`=0, load `fault_addr`=`lat_addr` (or `paddr` in the IDLE violation case) and `fault_code`, and set `fault_valid`.
  - Later errors do not overwrite the record.
  - `fault_clr` together with a new error in the same cycle: the new error is captured (set wins).

## Timing
- Reset values: state IDLE; `sel_idx`=0; `miss`=0; `tcnt`=0; `fault_valid`=0; `fault_addr`=0; `fault_code`=0.
- While `presetn`=0, all outputs are 0.
- Reset mid-transfer aborts immediately; the slave sees `s_psel` drop asynchronously.
- No added latency on any path:
  - Setup → slave `s_psel` in the same cycle.
  - Slave `s_pready` → master `pready` in the same cycle.
  - A zero-wait slave completes in 2 cycles (setup + access).
- Miss completes in 2 cycles.
- Timeout completes `TIMEOUT_CYCLES`+1 cycles after setup.
- `fault_*` update on the edge ending the error cycle, visible the next cycle.

## Test plan
- Read `'h80000010`, slave 0 zero-wait returning `'hDEADBEEF` → `s_psel`=001 in the setup cycle; `pready`=1 and `prdata`=`'hDEADBEEF` in the next cycle; `pslverr`=0.
- Write `'h10000005`, slave 1 holds `s_pready`=0 for 3 cycles → master `pready` low for 3 access cycles, then 1; `paddr` changed mid-access does not move the select.
- Access `'h20000000` → `pready`=1 and `pslverr`=1 in the first access cycle; next cycle `fault_valid`=1, `fault_addr`=`'h20000000`, `fault_code`=01.
- Slave 2 never ready, `TIMEOUT_CYCLES`=16 → forced `pready`/`pslverr` 17 cycles after setup; `s_psel`=0 in that cycle; `fault_code`=10.
- With a fault held, slave 0 returns `s_pslverr`=1 → record unchanged. Then `fault_clr` in the same cycle as a miss at `'h30000000` → record holds `'h30000000`, code 01.
- `presetn` pulsed low during a stalled access → all outputs 0 immediately; state IDLE; the next transfer decodes normally.

Source files
------------

// File: rtl/apb_fabric.sv
// apb_fabric: APB3 decoder/interconnect from one master port to NUM_SLAVES peripherals,
// with transfer-locked routing, timeout watchdog and a sticky first-error fault record.
module apb_fabric #(
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int NUM_SLAVES     = 3,
    // slave 0 occupies the least significant ADDR_WIDTH bits
    parameter logic [NUM_SLAVES*ADDR_WIDTH-1:0] SLAVE_BASE = {32'h00000000, 32'h10000000, 32'h80000000},
    parameter logic [NUM_SLAVES*ADDR_WIDTH-1:0] SLAVE_MASK = {32'hFFFF0000, 32'hFFFFFFF8, 32'h80000000},
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                             pclk,
    input  logic                             presetn,
    input  logic [ADDR_WIDTH-1:0]            paddr,
    input  logic                             psel,
    input  logic                             penable,
    output logic [DATA_WIDTH-1:0]            prdata,
    output logic                             pready,
    output logic                             pslverr,
    output logic [NUM_SLAVES-1:0]            s_psel,
    output logic [NUM_SLAVES-1:0]            s_penable,
    input  logic [NUM_SLAVES*DATA_WIDTH-1:0] s_prdata,
    input  logic [NUM_SLAVES-1:0]            s_pready,
    input  logic [NUM_SLAVES-1:0]            s_pslverr,
    output logic                             fault_valid,
    output logic [ADDR_WIDTH-1:0]            fault_addr,
    output logic [1:0]                       fault_code,
    input  logic                             fault_clr
);
    localparam int IW = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;
    localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TW-1:0] TMAX = TW'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

    typedef enum logic {S_IDLE = 1'b0, S_ACCESS = 1'b1} state_t;

    state_t                r_state, w_state_nxt;
    logic [IW-1:0]         r_sel_idx, w_hit_idx;
    logic                  r_miss, w_hit;
    logic [ADDR_WIDTH-1:0] r_lat_addr;
    logic [TW-1:0]         r_tcnt;
    logic                  r_fault_valid;
    logic [ADDR_WIDTH-1:0] r_fault_addr;
    logic [1:0]            r_fault_code;
    logic                  w_setup, w_viol, w_sel_rdy, w_sel_err, w_tmo, w_done, w_err;
    logic [DATA_WIDTH-1:0] w_sel_rdata;
    logic [ADDR_WIDTH-1:0] w_err_addr;
    logic [1:0]            w_err_code;

    // walk downward so the lowest hitting index is the one left standing
    always_comb begin
        w_hit     = 1'b0;
        w_hit_idx = '0;
        for (int i = NUM_SLAVES - 1; i >= 0; i--)
            if ((paddr & SLAVE_MASK[i*ADDR_WIDTH +: ADDR_WIDTH]) == SLAVE_BASE[i*ADDR_WIDTH +: ADDR_WIDTH]) begin
                w_hit     = 1'b1;
                w_hit_idx = IW'(i);
            end
    end

    assign w_setup     = (r_state == S_IDLE) && psel && !penable;
    assign w_viol      = (r_state == S_IDLE) && psel && penable;
    assign w_sel_rdy   = s_pready[r_sel_idx];
    assign w_sel_err   = s_pslverr[r_sel_idx];
    assign w_sel_rdata = s_prdata[r_sel_idx*DATA_WIDTH +: DATA_WIDTH];
    assign w_tmo       = (TIMEOUT_CYCLES != 0) && (r_state == S_ACCESS) && !r_miss && !w_sel_rdy && (r_tcnt == TMAX);
    assign w_done      = (r_state == S_ACCESS) && psel && (r_miss || w_tmo || w_sel_rdy);
    assign w_err       = w_viol || (w_done && (r_miss || w_tmo || w_sel_err));
    assign w_err_addr  = w_viol ? paddr : r_lat_addr;
    assign w_err_code  = (w_viol || r_miss) ? 2'b01 : (w_tmo ? 2'b10 : 2'b11);

    always_ff @(posedge pclk or negedge presetn)
        if (!presetn) r_state <= S_IDLE;
        else          r_state <= w_state_nxt;

    always_comb begin
        w_state_nxt = (r_state == S_IDLE) ? (w_setup ? S_ACCESS : S_IDLE)
                                          : ((!psel || w_done) ? S_IDLE : S_ACCESS);
    end

    always_comb begin
        s_psel    = '0;
        s_penable = '0;
        prdata    = '0;
        pready    = 1'b0;
        pslverr   = 1'b0;
        if (presetn) begin
            if (r_state == S_IDLE) begin
                if (w_setup && w_hit) s_psel[w_hit_idx] = 1'b1;
                pready  = w_viol;
                pslverr = w_viol;
            end else if (r_miss || w_tmo) begin
                pready  = 1'b1;
                pslverr = 1'b1;
            end else begin
                s_psel[r_sel_idx]    = psel;
                s_penable[r_sel_idx] = penable;
                prdata               = w_sel_rdata;
                pready               = w_sel_rdy;
                pslverr              = w_sel_err;
            end
        end
    end

    always_ff @(posedge pclk or negedge presetn)
        if (!presetn) begin
            r_sel_idx  <= '0;
            r_miss     <= 1'b0;
            r_lat_addr <= '0;
            r_tcnt     <= '0;
        end else if (w_setup) begin
            r_sel_idx  <= w_hit_idx;
            r_miss     <= !w_hit;
            r_lat_addr <= paddr;
            r_tcnt     <= '0;
        end else if (r_state == S_ACCESS && !w_sel_rdy) begin
            r_tcnt     <= r_tcnt + 1'b1;
        end

    // a clear in the same cycle as a new error still lets the error in
    always_ff @(posedge pclk or negedge presetn)
        if (!presetn) begin
            r_fault_valid <= 1'b0;
            r_fault_addr  <= '0;
            r_fault_code  <= '0;
        end else if (w_err && (!r_fault_valid || fault_clr)) begin
            r_fault_valid <= 1'b1;
            r_fault_addr  <= w_err_addr;
            r_fault_code  <= w_err_code;
        end else if (fault_clr) begin
            r_fault_valid <= 1'b0;
            r_fault_addr  <= '0;
            r_fault_code  <= '0;
        end

    assign fault_valid = r_fault_valid;
    assign fault_addr  = r_fault_addr;
    assign fault_code  = r_fault_code;
endmodule

// File: tb/tb_apb_fabric.sv
// tb_apb_fabric: directed and randomized transfers against a transfer-level model of the fabric.
module tb_apb_fabric;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int NS = 3;
    localparam int T  = 16;
    localparam logic [AW-1:0] BASE [NS] = '{32'h80000000, 32'h10000000, 32'h00000000};
    localparam logic [AW-1:0] MASK [NS] = '{32'h80000000, 32'hFFFFFFF8, 32'hFFFF0000};

    logic          pclk = 1'b0;
    logic          presetn, psel, penable, fault_clr;
    logic [AW-1:0] paddr;
    logic [DW-1:0] prdata;
    logic          pready, pslverr;
    logic [NS-1:0] s_psel, s_penable, s_pready, s_pslverr;
    logic [NS*DW-1:0] s_prdata;
    logic          fault_valid;
    logic [AW-1:0] fault_addr;
    logic [1:0]    fault_code;

    int            n_vec = 0;
    int            n_err = 0;
    logic          m_fv;
    logic [AW-1:0] m_fa;
    logic [1:0]    m_fc;

    apb_fabric #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_SLAVES(NS), .TIMEOUT_CYCLES(T)) dut (
        .pclk(pclk), .presetn(presetn), .paddr(paddr), .psel(psel), .penable(penable),
        .prdata(prdata), .pready(pready), .pslverr(pslverr),
        .s_psel(s_psel), .s_penable(s_penable), .s_prdata(s_prdata),
        .s_pready(s_pready), .s_pslverr(s_pslverr),
        .fault_valid(fault_valid), .fault_addr(fault_addr), .fault_code(fault_code),
        .fault_clr(fault_clr)
    );

    always #5 pclk = ~pclk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int decode(input logic [AW-1:0] a);
        for (int i = 0; i < NS; i++)
            if ((a & MASK[i]) == BASE[i]) return i;
        return -1;
    endfunction

    function automatic logic [NS-1:0] onehot(input int idx);
        return (idx < 0) ? '0 : NS'(1 << idx);
    endfunction

    function automatic logic [AW-1:0] rand_addr();
        case ($urandom_range(0, 4))
            0:       return {1'b1, 31'($urandom)};
            1:       return 32'h10000000 | 32'($urandom_range(0, 7));
            2:       return {16'h0000, 16'($urandom)};
            3:       return {4'h2, 28'($urandom)};
            default: return $urandom;
        endcase
    endfunction

    task automatic model_done(input logic err, input logic [AW-1:0] a, input logic [1:0] code, input logic clr);
        if (err && (!m_fv || clr)) begin
            m_fv = 1'b1; m_fa = a; m_fc = code;
        end else if (clr) begin
            m_fv = 1'b0; m_fa = '0; m_fc = '0;
        end
    endtask

    task automatic chk_fault();
        chk("fault_valid", fault_valid, m_fv);
        chk("fault_addr", fault_addr, m_fa);
        chk("fault_code", fault_code, m_fc);
    endtask

    // one transfer: setup, then access cycles until the model says it completes
    task automatic xfer(input logic [AW-1:0] a, input int waits, input logic serr, input logic clr, input logic [DW-1:0] d);
        int idx;
        logic rdy, done, e_err;
        logic [DW-1:0] e_d;
        logic [NS-1:0] e_sel;
        logic [1:0] code;
        idx = decode(a);
        paddr = a; psel = 1'b1; penable = 1'b0; fault_clr = 1'b0;
        s_pready = '0; s_pslverr = '0; s_prdata = {$urandom, $urandom, $urandom};
        #4;
        chk("setup_s_psel", s_psel, onehot(idx));
        chk("setup_s_penable", s_penable, '0);
        chk("setup_pready", pready, 1'b0);
        chk_fault();
        @(posedge pclk); #1;
        for (int k = 0; k <= T; k++) begin
            rdy  = (idx >= 0) && (k >= waits);
            done = (idx < 0) || rdy || (k == T - 1);
            paddr = $urandom; penable = 1'b1; fault_clr = clr && done;
            s_prdata = {$urandom, $urandom, $urandom};
            s_pready = NS'($urandom); s_pslverr = NS'($urandom);
            if (idx >= 0) begin
                s_prdata[idx*DW +: DW] = d; s_pready[idx] = rdy; s_pslverr[idx] = serr;
            end
            if (idx < 0) begin
                e_err = 1'b1; e_d = '0; e_sel = '0; code = 2'b01;
            end else if (rdy) begin
                e_err = serr; e_d = d; e_sel = onehot(idx); code = 2'b11;
            end else if (done) begin
                e_err = 1'b1; e_d = '0; e_sel = '0; code = 2'b10;
            end else begin
                e_err = 1'b0; e_d = '0; e_sel = onehot(idx); code = 2'b00;
            end
            #4;
            chk("acc_pready", pready, done);
            chk("acc_s_psel", s_psel, e_sel);
            chk("acc_s_penable", s_penable, e_sel);
            if (done) begin
                chk("acc_pslverr", pslverr, e_err);
                chk("acc_prdata", prdata, e_d);
            end
            @(posedge pclk); #1;
            if (done) begin
                model_done(e_err, a, code, clr);
                break;
            end
        end
        psel = 1'b0; penable = 1'b0; fault_clr = 1'b0;
    endtask

    task automatic viol(input logic [AW-1:0] a, input logic clr);
        paddr = a; psel = 1'b1; penable = 1'b1; fault_clr = clr;
        #4;
        chk("viol_pready", pready, 1'b1);
        chk("viol_pslverr", pslverr, 1'b1);
        chk("viol_prdata", prdata, '0);
        chk("viol_s_psel", s_psel, '0);
        @(posedge pclk); #1;
        model_done(1'b1, a, 2'b01, clr);
        psel = 1'b0; penable = 1'b0; fault_clr = 1'b0;
    endtask

    task automatic clr_only();
        psel = 1'b0; penable = 1'b0; fault_clr = 1'b1;
        #4;
        chk("idle_pready", pready, 1'b0);
        chk("idle_s_psel", s_psel, '0);
        @(posedge pclk); #1;
        model_done(1'b0, '0, 2'b00, 1'b1);
        fault_clr = 1'b0;
    endtask

    initial begin
        int r, w;
        presetn = 1'b0; psel = 1'b1; penable = 1'b1; paddr = 32'h80000010; fault_clr = 1'b0;
        s_pready = '1; s_pslverr = '1; s_prdata = {$urandom, $urandom, $urandom};
        m_fv = 1'b0; m_fa = '0; m_fc = '0;
        #4;
        chk("rst_pready", pready, 1'b0);
        chk("rst_pslverr", pslverr, 1'b0);
        chk("rst_s_psel", s_psel, '0);
        chk("rst_prdata", prdata, '0);
        chk_fault();
        penable = 1'b0;
        #1;
        chk("rst_setup_s_psel", s_psel, '0);
        @(posedge pclk); #1;
        presetn = 1'b1; psel = 1'b0; penable = 1'b0;

        xfer(32'h80000010, 0, 1'b0, 1'b0, 32'hDEADBEEF);
        xfer(32'h10000005, 3, 1'b0, 1'b0, 32'h12345678);
        xfer(32'h20000000, 0, 1'b0, 1'b0, 32'h0);
        chk_fault();
        clr_only();
        chk_fault();
        xfer(32'h00001234, 99, 1'b0, 1'b0, $urandom);
        chk_fault();
        xfer(32'h80000020, 0, 1'b1, 1'b0, $urandom);
        chk_fault();
        xfer(32'h30000000, 0, 1'b0, 1'b1, 32'h0);
        chk_fault();
        viol(32'h90000000, 1'b0);
        clr_only();
        viol(32'h90000000, 1'b0);
        chk_fault();

        paddr = 32'h00000100; psel = 1'b1; penable = 1'b0; s_pready = 3'b011;
        #4;
        chk("stall_setup_s_psel", s_psel, 3'b100);
        @(posedge pclk); #1;
        penable = 1'b1;
        repeat (3) begin
            #4;
            chk("stall_pready", pready, 1'b0);
            @(posedge pclk); #1;
        end
        #2;
        presetn = 1'b0;
        #1;
        m_fv = 1'b0; m_fa = '0; m_fc = '0;
        chk("arst_s_psel", s_psel, '0);
        chk("arst_s_penable", s_penable, '0);
        chk("arst_pready", pready, 1'b0);
        chk("arst_pslverr", pslverr, 1'b0);
        chk("arst_prdata", prdata, '0);
        chk_fault();
        psel = 1'b0; penable = 1'b0;
        @(posedge pclk); #1;
        presetn = 1'b1;
        xfer(32'h80000044, 1, 1'b0, 1'b0, $urandom);

        for (int n = 0; n < 300; n++) begin
            r = $urandom_range(0, 19);
            w = $urandom_range(0, 9);
            if (r == 0) viol(rand_addr(), 1'($urandom));
            else if (r == 1) clr_only();
            else xfer(rand_addr(), (w < 6) ? w % 3 : ((w < 8) ? 5 : 99),
                      $urandom_range(0, 3) == 0, $urandom_range(0, 4) == 0, $urandom);
        end
        chk_fault();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
